jtag_master: RTL
================

JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 The block SHALL have the port TCK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port TRST, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port cmd_valid, input, 1 bit: a command is offered.
REQ-004 The block SHALL have the port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-005 The block SHALL have the port cmd_type, input, 2 bits, encoded as: 00 TAP_RESET, 01 IDLE_WAIT, 10 SHIFT_IR, 11 SHIFT_DR.
REQ-006 The block SHALL have the port cmd_len, input, 5 bits: the bit/cycle count minus 1 (range 1..32).
REQ-007 The block SHALL have the port cmd_data, input, 32 bits: the shift-in payload, LSB shifted first.
REQ-008 The block SHALL have the port TMS, output, 1 bit: the test mode select driven to the target TAP.
REQ-009 The block SHALL have the port TDI, output, 1 bit: the serial data to the target.
REQ-010 The block SHALL have the port TDO, input, 1 bit: the serial data from the target.
REQ-011 The block SHALL have the port rsp_valid, output, 1 bit: a one-cycle pulse when a shift completes.
REQ-012 The block SHALL have the port rsp_data, output, 32 bits: the captured TDO bits.
REQ-013 The block SHALL have the port tap_state, output, 4 bits: the mirror of the target TAP state.
REQ-014 The tap_state encoding SHALL be: 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PauseDR, 7 Ex2DR, 8 UpdDR, 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PauseIR, 14 Ex2IR, 15 UpdIR.

Function
REQ-015 TMS and TDI SHALL be registered outputs that change only on the TCK rising edge, giving one TMS/TDI value per cycle ("slot").
REQ-016 The target is defined to sample each slot at the rising edge that ends it; tap_state SHALL advance at that edge per IEEE 1149.1 transitions using the current TMS.
REQ-017 cmd_ready SHALL be 1 only in the controller's READY state with tap_state=RTI; a command is accepted when cmd_valid and cmd_ready are both 1, and cmd_ready SHALL drop in the following cycle.
REQ-018 cmd_type, cmd_len and cmd_data SHALL be latched at acceptance; later changes to them SHALL be ignored, and cmd_valid while cmd_ready=0 SHALL be ignored.
REQ-019 With L = cmd_len+1, the TMS slot sequences starting the cycle after acceptance SHALL be:
  - TAP_RESET: 1,1,1,1,1,0 (6 slots).
  - IDLE_WAIT: 0 repeated L times.
  - SHIFT_IR: 1,1,0,0, then L shift slots, then 1,0 (L+6 slots).
  - SHIFT_DR: 1,0,0, then L shift slots, then 1,0 (L+5 slots).
REQ-020 In shift slots, TMS SHALL be 0 except in the last shift slot, where it SHALL be 1 (exit to Ex1).
REQ-021 TDI SHALL be cmd_data[i] in shift slot i (i=0..L-1) and 0 in every other slot.
REQ-022 TDO SHALL be sampled at the edge ending shift slot i into bit i of a capture register; bits L..31 SHALL be 0.
REQ-023 In the cycle after the final TMS=0 slot of SHIFT_IR or SHIFT_DR, rsp_valid SHALL be 1 for exactly one cycle with rsp_data = the capture register.
REQ-024 rsp_data SHALL hold its value until the next response; TAP_RESET and IDLE_WAIT SHALL NOT pulse rsp_valid.
REQ-025 cmd_ready SHALL be 1 in the same cycle as rsp_valid, so back-to-back commands incur no idle slot beyond the final RTI slot.
REQ-026 L=1 and L=32 SHALL be handled: a single shift slot carries TMS=1, and all 32 data bits are used, respectively.
REQ-027 The controller SHALL contain an explicit FSM with states INIT_RESET, READY, PREAMBLE, SHIFT, POSTAMBLE, IDLE_RUN and a 5-bit slot counter; unused encodings SHALL recover to INIT_RESET.

Reset
REQ-028 While TRST=1, the block SHALL hold TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, tap_state=TLR, and FSM=INIT_RESET.
REQ-029 After TRST falls, the block SHALL autonomously drive TMS 1,1,1,1,1,0 and then enter READY, with tap_state=RTI and cmd_ready=1 in the 7th cycle after reset release.
REQ-030 TRST asserted mid-command SHALL abort it with no rsp_valid; the captured bits SHALL be discarded, and the REQ-029 sequence SHALL restart.

Verification
REQ-031 Reset release -> TMS=1 for 5 cycles, then 0; cmd_ready rises in cycle 7; tap_state goes TLR then RTI.
REQ-032 SHIFT_IR, cmd_len=3, cmd_data=0xA, TDO tied 1 -> TMS 1,1,0,0,0,0,0,1,1,0; TDI 0,0,0,0,0,1,0,1,0,0; rsp_data=0x0000000F.
REQ-033 SHIFT_DR, cmd_len=31, cmd_data=0xDEADBEEF, TDO looped from delayed TDI -> 37 slots; rsp_data=0xDEADBEEF; rsp_valid high exactly 1 cycle.
REQ-034 SHIFT_DR, cmd_len=0, cmd_data=1, TDO=0 -> TMS 1,0,0,1,1,0; TDI 1 in slot 3 only; rsp_data=0.
REQ-035 TRST pulsed during the SHIFT slots of a SHIFT_IR -> no rsp_valid; the 6-slot reset sequence repeats; a subsequent command completes normally.
REQ-036 IDLE_WAIT, cmd_len=9, with cmd_valid held high and cmd_data toggling -> 10 TMS=0 slots; tap_state stays RTI; the second command is accepted only after completion.

Source files
------------

// File: rtl/jtag_master.sv
// JTAG master: turns TAP_RESET / IDLE_WAIT / SHIFT_IR / SHIFT_DR commands into
// registered TMS/TDI slots, captures TDO and mirrors the target TAP state.
module jtag_master (
  input  logic        TCK,
  input  logic        TRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        TMS,
  output logic        TDI,
  input  logic        TDO,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [3:0]  tap_state
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  localparam logic [1:0] CMD_TAP_RESET = 2'b00;
  localparam logic [1:0] CMD_IDLE_WAIT = 2'b01;
  localparam logic [1:0] CMD_SHIFT_IR  = 2'b10;

  typedef enum logic [2:0] {
    INIT_RESET = 3'd0,
    READY      = 3'd1,
    PREAMBLE   = 3'd2,
    SHIFT      = 3'd3,
    POSTAMBLE  = 3'd4,
    IDLE_RUN   = 3'd5
  } ctrl_e;

  typedef enum logic [3:0] {
    TAP_TLR     = 4'd0,  TAP_RTI     = 4'd1,  TAP_SEL_DR  = 4'd2,  TAP_CAP_DR  = 4'd3,
    TAP_SH_DR   = 4'd4,  TAP_EX1_DR  = 4'd5,  TAP_PAU_DR  = 4'd6,  TAP_EX2_DR  = 4'd7,
    TAP_UPD_DR  = 4'd8,  TAP_SEL_IR  = 4'd9,  TAP_CAP_IR  = 4'd10, TAP_SH_IR   = 4'd11,
    TAP_EX1_IR  = 4'd12, TAP_PAU_IR  = 4'd13, TAP_EX2_IR  = 4'd14, TAP_UPD_IR  = 4'd15
  } tap_e;

  // IEEE 1149.1 TAP transition for one TCK edge.
  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      TAP_TLR:    tap_next = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    tap_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: tap_next = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: tap_next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  tap_next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: tap_next = tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: tap_next = tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: tap_next = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: tap_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: tap_next = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: tap_next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  tap_next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: tap_next = tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: tap_next = tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: tap_next = tms ? TAP_UPD_IR : TAP_SH_IR;
      default:    tap_next = tms ? TAP_SEL_DR : TAP_RTI;
    endcase
  endfunction

  ctrl_e          state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tms_q, tms_d;
  logic           tdi_q, tdi_d;
  logic           ready_q, ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  tap_e           tap_q, tap_d;
  logic [1:0]     type_q, type_d;
  logic [CW-1:0]  len_q, len_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  cap_q, cap_d;
  logic           sh_act_q, sh_act_d;
  logic [CW-1:0]  sh_idx_q, sh_idx_d;
  logic           accept_c;

  assign accept_c = cmd_valid && ready_q;

  // Target TAP mirror: the target samples the slot currently on TMS.
  always_comb begin
    tap_d = tap_next(tap_q, tms_q);
  end

  // Controller: state/cnt name the next slot to issue; each edge issues one slot.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    type_d      = type_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    sh_act_d    = 1'b0;
    sh_idx_d    = sh_idx_q;

    // TDO is sampled at the edge that ends a shift slot.
    if (sh_act_q) cap_d[sh_idx_q] = TDO;

    case (state_q)
      INIT_RESET: begin
        tms_d = (cnt_q != 5'd5);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd5) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        // First READY edge after a shift's final slot reports the capture.
        if (!ready_q && type_q[1]) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
        end
        if (accept_c) begin
          type_d = cmd_type;
          len_d  = cmd_len;
          data_d = cmd_data;
          cap_d  = '0;
          cnt_d  = 5'd1;
          case (cmd_type)
            CMD_TAP_RESET: begin
              tms_d   = 1'b1;
              state_d = INIT_RESET;
            end
            CMD_IDLE_WAIT: begin
              tms_d   = 1'b0;
              state_d = (cmd_len == 5'd0) ? READY : IDLE_RUN;
            end
            default: begin
              tms_d   = 1'b1;
              state_d = PREAMBLE;
            end
          endcase
        end
      end
      PREAMBLE: begin
        // IR path walks SelDR->SelIR->CapIR->ShIR, DR path SelDR->CapDR->ShDR.
        tms_d = (type_q == CMD_SHIFT_IR) && (cnt_q == 5'd1);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ((type_q == CMD_SHIFT_IR) ? 5'd3 : 5'd2)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        tms_d    = (cnt_q == len_q);
        tdi_d    = data_q[cnt_q];
        sh_act_d = 1'b1;
        sh_idx_d = cnt_q;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == len_q) begin
          state_d = POSTAMBLE;
          cnt_d   = '0;
        end
      end
      POSTAMBLE: begin
        tms_d = (cnt_q == 5'd0);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q != 5'd0) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      IDLE_RUN: begin
        tms_d = 1'b0;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == len_q) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT_RESET;
        cnt_d   = '0;
        tms_d   = 1'b1;
      end
    endcase

    ready_d = (state_q == READY) && !accept_c && (tap_d == TAP_RTI);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q     <= INIT_RESET;
      cnt_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tap_q       <= TAP_TLR;
      type_q      <= CMD_TAP_RESET;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      sh_act_q    <= 1'b0;
      sh_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tap_q       <= tap_d;
      type_q      <= type_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      sh_act_q    <= sh_act_d;
      sh_idx_q    <= sh_idx_d;
    end
  end

  assign cmd_ready = ready_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tap_state = 4'(tap_q);

endmodule
